// File: rtl/inst_fetch_queue.sv
// Decoupled instruction-fetch queue: variable-latency IMem requests, circular PC/instruction buffer, redirect flush.
// Optional macro IFQ_STATS_EN adds the FlushCount output (flushed entries plus discarded responses).
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic [63:0]   startPC,
  input  logic          Redirect,
  input  logic [63:0]   RedirectPC,
  output logic          IMemReq,
  output logic [63:0]   IMemAddr,
  input  logic          IMemAck,
  input  logic [31:0]   IMemData,
  input  logic          IFIDReady,
  output logic          InstValid,
  output logic [31:0]   Instruction,
  output logic [63:0]   InstPC,
  output logic [CW-1:0] Count
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]   FlushCount
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_START, S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        state, nextState;
  logic [63:0]   fetchPC, discardAddr;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [31:0]   instMem [DEPTH];
  logic [63:0]   pcMem   [DEPTH];
  logic          redirectEff, deq, enq, holdAddr;
  logic [CW-1:0] countAfter;

  assign InstValid   = (Count != '0);
  assign Instruction = InstValid ? instMem[rdPtr] : '0;
  assign InstPC      = InstValid ? pcMem[rdPtr]   : '0;

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= S_START;
    else          state <= nextState;
  end

  always_comb begin
    nextState   = state;
    IMemReq     = 1'b0;
    IMemAddr    = '0;
    holdAddr    = 1'b0;
    redirectEff = Redirect && (state != S_START);
    // A dequeue coinciding with a redirect is void: downstream flushes too.
    deq         = InstValid && IFIDReady && !redirectEff;
    enq         = (state == S_REQ) && IMemAck && !redirectEff;
    countAfter  = Count + CW'(enq) - CW'(deq);
    unique case (state)
      S_START: nextState = S_IDLE;
      S_IDLE: begin
        if (!redirectEff && (countAfter < DEPTH_C)) nextState = S_REQ;
      end
      S_REQ: begin
        IMemReq  = 1'b1;
        IMemAddr = fetchPC;
        if (redirectEff) begin
          nextState = IMemAck ? S_IDLE : S_DISCARD;
          holdAddr  = !IMemAck;
        end else if (IMemAck) begin
          nextState = (countAfter < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        IMemReq  = 1'b1;
        IMemAddr = discardAddr;
        if (IMemAck) nextState = S_IDLE;
      end
      default: nextState = S_START;
    endcase
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetchPC     <= '0;
      discardAddr <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      Count       <= '0;
    end else begin
      if (state == S_START)  fetchPC <= startPC;
      else if (redirectEff)  fetchPC <= RedirectPC;
      else if (enq)          fetchPC <= fetchPC + 64'd4;
      if (holdAddr) discardAddr <= fetchPC;
      if (redirectEff) begin
        rdPtr <= '0;
        wrPtr <= '0;
        Count <= '0;
      end else begin
        if (enq) wrPtr <= wrPtr + PW'(1);
        if (deq) rdPtr <= rdPtr + PW'(1);
        Count <= countAfter;
      end
    end
  end

  // Storage needs no reset: the outputs are masked whenever the queue is empty.
  always_ff @(negedge CLK) begin
    if (enq) begin
      instMem[wrPtr] <= IMemData;
      pcMem[wrPtr]   <= fetchPC;
    end
  end

`ifdef IFQ_STATS_EN
  logic [32:0] flushSum;

  // An S_REQ response is always lost on redirect (acked now or discarded later).
  always_comb flushSum = {1'b0, FlushCount} + 33'(Count) + 33'(state == S_REQ);

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L)         FlushCount <= '0;
    else if (redirectEff) FlushCount <= flushSum[32] ? '1 : flushSum[31:0];
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          Reset_L;
  logic [63:0]   startPC, RedirectPC, IMemAddr, InstPC;
  logic          Redirect, IMemReq, IMemAck, IFIDReady, InstValid;
  logic [31:0]   IMemData, Instruction;
  logic [CW-1:0] Count;
`ifdef IFQ_STATS_EN
  logic [31:0]   FlushCount;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemData(IMemData), .IFIDReady(IFIDReady),
    .InstValid(InstValid), .Instruction(Instruction), .InstPC(InstPC), .Count(Count)
`ifdef IFQ_STATS_EN
    , .FlushCount(FlushCount)
`endif
  );

  always #5 CLK = ~CLK;

  int tot = 0;
  int bad = 0;

  // Reference model: a queue of fetched entries; a request is up whenever the queue has room.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          started, reqOn, discarding;
  logic [63:0] mPC, mDisc;
  longint unsigned mFlush;
  int          waitCnt, curLat, latMode;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [63:0] expAddr();
    return discarding ? mDisc : (reqOn ? mPC : 64'h0);
  endfunction

  task automatic model_reset();
    mq.delete();
    started = 0; reqOn = 0; discarding = 0;
    mPC = '0; mDisc = '0; mFlush = 0;
    waitCnt = 0;
    curLat = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
  endtask

  task automatic model_update(input bit redir, input logic [63:0] rpc, input bit rdy, input bit ack);
    longint unsigned f;
    if (!started) begin
      mPC = startPC; started = 1;
      return;
    end
    if (redir) begin
      f = mFlush + longint'(mq.size()) + ((reqOn && !discarding) ? 1 : 0);
      mFlush = (f > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : f;
      if (discarding) begin
        if (ack) begin discarding = 0; reqOn = 0; end
      end else if (reqOn) begin
        if (ack) reqOn = 0;
        else begin discarding = 1; mDisc = mPC; end
      end
      mq.delete();
      mPC = rpc;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (discarding) begin
        if (ack) begin discarding = 0; reqOn = 0; end
      end else begin
        if (reqOn && ack) begin
          mq.push_back('{mPC, memWord(mPC)});
          mPC = mPC + 64'd4;
        end
        reqOn = (mq.size() < DEPTH);
      end
    end
  endtask

  task automatic step(input bit redir, input logic [63:0] rpc, input bit rdy);
    bit ack, pre;
    ack = reqOn && (waitCnt >= curLat);
    pre = reqOn;
    Redirect = redir; RedirectPC = rpc; IFIDReady = rdy; IMemAck = ack;
    IMemData = ack ? memWord(IMemAddr) : 32'h0;
    @(negedge CLK);
    model_update(redir, rpc, rdy, ack);
    if (ack) begin
      waitCnt = 0;
      curLat = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
    end else if (pre) waitCnt++;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input logic [63:0] spc);
    Reset_L = 1'b0; Redirect = 0; RedirectPC = '0; IMemAck = 0; IMemData = '0;
    IFIDReady = 0; startPC = spc;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    Reset_L = 1'b1;
  endtask

  task automatic test_reset();
    latMode = 0;
    Reset_L = 1'b0; Redirect = 0; RedirectPC = '0; IMemAck = 0; IMemData = '0;
    IFIDReady = 1; startPC = 64'h100;
    @(posedge CLK); #1;
    tot++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", IMemReq); end
    tot++; if (IMemAddr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", IMemAddr); end
    tot++; if (InstValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", InstValid); end
    tot++; if (Instruction !== 32'h0) begin bad++; $display("FAIL reset_inst got=%0h exp=0", Instruction); end
    tot++; if (InstPC !== 64'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", InstPC); end
    tot++; if (Count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
`ifdef IFQ_STATS_EN
    tot++; if (FlushCount !== 32'h0) begin bad++; $display("FAIL reset_flush got=%0d exp=0", FlushCount); end
`endif
  endtask

  task automatic test_startup();
    logic [63:0] obs[$];
    logic [63:0] want;
    latMode = 0;
    do_reset(64'h100);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    tot++; if (InstValid !== 1'b1) begin bad++; $display("FAIL start_valid3 got=%0h exp=1", InstValid); end
    for (int i = 0; i < 5; i++) begin
      if (InstValid === 1'b1) obs.push_back(InstPC);
      tot++; if (InstPC !== (mq.size() ? mq[0].pc : 64'h0)) begin bad++; $display("FAIL start_pc got=%0h exp=%0h", InstPC, mq.size() ? mq[0].pc : 64'h0); end
      step(0, '0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      want = 64'h100 + 64'(4 * i);
      tot++;
      if (obs.size() <= i || obs[i] !== want) begin
        bad++; $display("FAIL start_seq%0d got=%0h exp=%0h", i, (obs.size() > i) ? obs[i] : 64'hx, want);
      end
    end
  endtask

  task automatic test_fill();
    latMode = 0;
    do_reset(64'h100);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 0);
      tot++; if (Count !== CW'(mq.size())) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", Count, mq.size()); end
    end
    tot++; if (Count !== CW'(4)) begin bad++; $display("FAIL fill_full got=%0d exp=4", Count); end
    tot++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL fill_noreq got=%0h exp=0", IMemReq); end
    step(0, '0, 1);
    tot++; if (IMemReq !== 1'b1 || IMemAddr !== 64'h110) begin bad++; $display("FAIL fill_resume got=%0h/%0h exp=1/110", IMemReq, IMemAddr); end
    tot++; if (Count !== CW'(3)) begin bad++; $display("FAIL fill_pop got=%0d exp=3", Count); end
  endtask

  task automatic test_latency();
    latMode = 3;
    do_reset(64'h200);
    step(0, '0, 0);
    step(0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      tot++; if (IMemReq !== 1'b1 || IMemAddr !== 64'h200) begin bad++; $display("FAIL lat_hold%0d got=%0h/%0h exp=1/200", i, IMemReq, IMemAddr); end
      tot++; if (Count !== CW'(0)) begin bad++; $display("FAIL lat_wait%0d got=%0d exp=0", i, Count); end
      step(0, '0, 0);
    end
    tot++; if (Count !== CW'(1) || InstPC !== 64'h200) begin bad++; $display("FAIL lat_enq got=%0d/%0h exp=1/200", Count, InstPC); end
    tot++; if (Instruction !== memWord(64'h200)) begin bad++; $display("FAIL lat_data got=%0h exp=%0h", Instruction, memWord(64'h200)); end
    tot++; if (IMemAddr !== 64'h204) begin bad++; $display("FAIL lat_next got=%0h exp=204", IMemAddr); end
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    tot++; if (Count !== CW'(1)) begin bad++; $display("FAIL lat_once got=%0d exp=1", Count); end
  endtask

  task automatic test_redirect_discard();
    bit seen;
    latMode = 0;
    do_reset(64'h200);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    latMode = 3;
    step(0, '0, 1);
    tot++; if (IMemReq !== 1'b1 || IMemAddr !== 64'h20C) begin bad++; $display("FAIL rd_pend got=%0h/%0h exp=1/20c", IMemReq, IMemAddr); end
    step(1, 64'h400, 1);
    tot++; if (Count !== CW'(0) || InstValid !== 1'b0) begin bad++; $display("FAIL rd_flush got=%0d/%0h exp=0/0", Count, InstValid); end
    tot++; if (IMemReq !== 1'b1 || IMemAddr !== 64'h20C) begin bad++; $display("FAIL rd_hold got=%0h/%0h exp=1/20c", IMemReq, IMemAddr); end
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(0, '0, 1);
      tot++; if (InstValid === 1'b1 && InstPC === 64'h20C) begin bad++; $display("FAIL rd_leak got=%0h exp=none", InstPC); end
      if (IMemReq === 1'b1 && IMemAddr === 64'h400) seen = 1;
    end
    tot++; if (!seen) begin bad++; $display("FAIL rd_target got=%0h exp=400", IMemAddr); end
    tot++; if (Count !== CW'(mq.size())) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", Count, mq.size()); end
  endtask

  task automatic test_flush_count();
`ifdef IFQ_STATS_EN
    logic [31:0] fc0;
`endif
    latMode = 0;
    do_reset(64'h300);
    for (int i = 0; i < 5; i++) step(0, '0, 0);
    tot++; if (Count !== CW'(3)) begin bad++; $display("FAIL fl_pre got=%0d exp=3", Count); end
`ifdef IFQ_STATS_EN
    fc0 = FlushCount;
`endif
    step(1, 64'h500, 1);
    tot++; if (Count !== CW'(0) || InstValid !== 1'b0) begin bad++; $display("FAIL fl_count got=%0d/%0h exp=0/0", Count, InstValid); end
    tot++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL fl_req got=%0h exp=0", IMemReq); end
`ifdef IFQ_STATS_EN
    tot++; if (FlushCount !== fc0 + 32'd4) begin bad++; $display("FAIL fl_stats got=%0d exp=%0d", FlushCount, fc0 + 32'd4); end
`endif
    step(0, '0, 1);
    tot++; if (IMemReq !== 1'b1 || IMemAddr !== 64'h500) begin bad++; $display("FAIL fl_restart got=%0h/%0h exp=1/500", IMemReq, IMemAddr); end
  endtask

  task automatic test_random();
    bit redir, rdy;
    logic [63:0] rpc;
    latMode = -1;
    do_reset(64'hFFFF_FFFF_FFFF_FFF3);
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(0, 99) < 6);
      rdy   = ($urandom_range(0, 99) < 60);
      rpc   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))}
                                           : {$urandom, $urandom};
      step(redir, rpc, rdy);
      tot++; if (IMemReq !== reqOn) begin bad++; $display("FAIL rnd_req@%0d got=%0h exp=%0h", i, IMemReq, reqOn); end
      tot++; if (IMemAddr !== expAddr()) begin bad++; $display("FAIL rnd_addr@%0d got=%0h exp=%0h", i, IMemAddr, expAddr()); end
      tot++; if (Count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", i, Count, mq.size()); end
      tot++; if (InstValid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d got=%0h exp=%0h", i, InstValid, mq.size() != 0); end
      tot++; if (InstPC !== (mq.size() ? mq[0].pc : 64'h0)) begin bad++; $display("FAIL rnd_pc@%0d got=%0h exp=%0h", i, InstPC, mq.size() ? mq[0].pc : 64'h0); end
      tot++; if (Instruction !== (mq.size() ? mq[0].inst : 32'h0)) begin bad++; $display("FAIL rnd_inst@%0d got=%0h exp=%0h", i, Instruction, mq.size() ? mq[0].inst : 32'h0); end
`ifdef IFQ_STATS_EN
      tot++; if (FlushCount !== mFlush[31:0]) begin bad++; $display("FAIL rnd_flush@%0d got=%0d exp=%0d", i, FlushCount, mFlush); end
`endif
    end
  endtask

  task automatic test_async_reset();
    latMode = 0;
    do_reset(64'h100);
    for (int i = 0; i < 4; i++) step(0, '0, 0);
    tot++; if (IMemReq !== 1'b1 || Count !== CW'(2)) begin bad++; $display("FAIL ar_pre got=%0h/%0d exp=1/2", IMemReq, Count); end
    #2;
    Reset_L = 1'b0;
    #1;
    tot++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL ar_req got=%0h exp=0", IMemReq); end
    tot++; if (InstValid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h exp=0", InstValid); end
    tot++; if (Count !== CW'(0)) begin bad++; $display("FAIL ar_count got=%0d exp=0", Count); end
    tot++; if (IMemAddr !== 64'h0) begin bad++; $display("FAIL ar_addr got=%0h exp=0", IMemAddr); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_fill();
    test_latency();
    test_redirect_discard();
    test_flush_count();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupled instruction-fetch front end for the 5-stage LEGv8 pipeline; sits directly upstream of the IF/ID register and replaces the fixed PC+4 fetch.
- Issues requests to a variable-latency instruction memory, buffers returned instructions with their PCs in a circular queue, and presents them to IF/ID with a valid/ready handshake.
- Taken-branch redirects from the MEM stage flush the queue and restart fetch at the branch target.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- CW, 3, width of Count; equals log2(DEPTH)+1

Ports:
- CLK  in  1  clock; all state updates on negedge CLK, matching the pipeline registers
- Reset_L  in  1  reset, asynchronous, active-low
- startPC  in  64  fetch start address, loaded in the first cycle after reset release
- Redirect  in  1  taken branch from MEM stage (PCSrc)
- RedirectPC  in  64  branch target (branchAddr4)
- IMemReq  out  1  fetch request to instruction memory
- IMemAddr  out  64  fetch address; stable while IMemReq is high
- IMemAck  in  1  memory returns IMemData this cycle
- IMemData  in  32  instruction word
- IFIDReady  in  1  IF/ID accepts an instruction this cycle
- InstValid  out  1  Instruction/InstPC hold a valid queue head
- Instruction  out  32  head instruction
- InstPC  out  64  PC of the head instruction
- Count  out  CW  current queue occupancy, 0..DEPTH

Behaviour:
- Reset values: IMemReq=0, IMemAddr=0, InstValid=0, Instruction=0, InstPC=0, Count=0, state=S_START, read/write pointers=0.
- FSM states:
  - S_START: fetchPC<=startPC; Redirect is ignored; next state S_IDLE.
  - S_IDLE: IMemReq=0. Moves to S_REQ when Count < DEPTH, with space reserved for one response.
  - S_REQ: IMemReq=1, IMemAddr=fetchPC. On IMemAck: enqueue {fetchPC, IMemData}, fetchPC+=4, go to S_REQ if space remains after the enqueue, else S_IDLE.
  - S_DISCARD: IMemReq=1 holding the old address. On IMemAck: drop the data, go to S_IDLE.
- Handshake rules:
  - A request is held until acked; zero-wait ack (same cycle as request) is legal.
  - At most one outstanding request.
- Dequeue: occurs when InstValid & IFIDReady at the clock edge; pop the head.
  - Instruction/InstPC are driven from the head entry combinationally.
  - InstValid = (Count != 0).
- Simultaneous enqueue and dequeue: both take effect; Count unchanged. Overflow is impossible because a request issues only when Count - (dequeue ? 1 : 0) < DEPTH.
- Redirect (not in S_START):
  - Queue flushes: pointers=0, Count=0.
  - fetchPC<=RedirectPC.
  - Any same-cycle dequeue is void, because downstream also flushes.
  - In S_REQ without IMemAck: go to S_DISCARD.
  - In S_REQ with IMemAck: data dropped, go to S_IDLE.
  - In S_IDLE: go to S_IDLE with the new PC.
  - In S_DISCARD: update fetchPC, remain in S_DISCARD.
- Redirect in S_DISCARD coinciding with IMemAck: drop the data, take the newest RedirectPC, go to S_IDLE.
- fetchPC arithmetic: 64-bit, wraps modulo 2^64. Low two bits pass through unchanged and are not checked.
- Pointers wrap modulo DEPTH.
- Reset mid-fetch: all state cleared asynchronously. The outstanding memory response is not tracked; the memory is reset on the same Reset_L.

Optional Feature:
- Macro IFQ_STATS_EN.
- When defined:
  - Adds output FlushCount (32 bits, reset 0).
  - On each Redirect, adds the number of flushed queue entries, plus 1 if the outstanding response will be or is being discarded.
  - Saturates at 32'hFFFFFFFF.
- When undefined: port absent, no counter logic.

Test Plan:
- Reset release with startPC=0x100, IMemAck tied high, IFIDReady high -> InstPC sequence 0x100, 0x104, 0x108; first InstValid within 3 cycles of release.
- IFIDReady low, ack always high, DEPTH=4 -> Count reaches 4, IMemReq drops to 0, no further requests; raising IFIDReady resumes fetch at 0x110.
- Ack latency 3 cycles, IMemAddr=0x200 -> IMemAddr held at 0x200 for all 3 cycles; entry PC 0x200 enqueued once.
- Redirect to 0x400 while a request for 0x20C is outstanding -> S_DISCARD; the 0x20C data is never presented; next request address 0x400; Count=0 immediately after the redirect.
- Redirect with Count=3 and a same-cycle IFIDReady -> no dequeue counted, Count=0; with IFQ_STATS_EN, FlushCount increments by 3 (or 4 if a request is outstanding).
- Async Reset_L pulse mid-S_REQ -> IMemReq=0, InstValid=0, Count=0 immediately, without waiting for a clock edge.
